// File: rtl/dmem_bus_bridge_pkg.sv
// Shared definitions for the data-memory bus bridge: FSM states, store/load
// encoding of the core's we_re bit, and the read data returned on error.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam logic WE_STORE = 1'b1;
   localparam logic WE_LOAD  = 1'b0;

   localparam int DMEM_ERR_DATA = 0;

endpackage

// File: rtl/dmem_bus_bridge_timeout_ctr.sv
// Bounded-wait counter for the bridge. tc flags the last permitted busy cycle,
// so a transaction that has not completed by then ends after TIMEOUT cycles.
module bus_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         count <= '0;
      end else if (enable && !tc) begin
         count <= count + 1'b1;
      end
   end

   // count holds the number of busy cycles already elapsed before this one
   assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bus_bridge.sv
// Registered bridge from the core data-memory port to a req/gnt/rvalid slave.
// One transaction in flight; every output is a flop.
module dmem_bus_bridge
   import core_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                core_req,
   input  logic                core_we_re,
   input  logic [DATA_W/8-1:0] core_mask,
   input  logic [ADDR_W-1:0]   core_addr,
   input  logic [DATA_W-1:0]   core_wdata,
   output logic                core_valid,
   output logic [DATA_W-1:0]   core_rdata,
   output logic                core_err,
   output logic                busy,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int BE_W = DATA_W / 8;

   dmem_state_t       state, state_n;
   logic              tc;
   logic              valid_n, err_n;
   logic [DATA_W-1:0] rdata_n;
   logic              we_n;
   logic [BE_W-1:0]   be_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] wdata_n;

   bus_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == IDLE),
      .enable (state != IDLE),
      .tc     (tc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         core_valid <= 1'b0;
         core_rdata <= '0;
         core_err   <= 1'b0;
         busy       <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_n;
         core_valid <= valid_n;
         core_rdata <= rdata_n;
         core_err   <= err_n;
         busy       <= (state_n != IDLE);
         mem_req    <= (state_n == REQ);
         mem_we     <= we_n;
         mem_be     <= be_n;
         mem_addr   <= addr_n;
         mem_wdata  <= wdata_n;
      end
   end

   // The mem_* flops double as the capture registers for the request.
   always_comb begin
      state_n = state;
      valid_n = 1'b0;
      err_n   = 1'b0;
      rdata_n = '0;
      we_n    = mem_we;
      be_n    = mem_be;
      addr_n  = mem_addr;
      wdata_n = mem_wdata;
      case (state)
         IDLE: begin
            if (core_req) begin
               if (core_mask != '0) begin
                  state_n = REQ;
                  we_n    = core_we_re;
                  be_n    = core_mask;
                  addr_n  = core_addr;
                  wdata_n = core_wdata;
               end else begin
                  valid_n = 1'b1;
               end
            end
         end
         REQ: begin
            if (tc) begin
               state_n = IDLE;
               valid_n = 1'b1;
               err_n   = 1'b1;
               rdata_n = DATA_W'(DMEM_ERR_DATA);
            end else if (mem_gnt) begin
               state_n = RESP;
            end
         end
         RESP: begin
            // A response in the terminal cycle still counts as a normal completion.
            if (mem_rvalid) begin
               state_n = IDLE;
               valid_n = 1'b1;
               rdata_n = (mem_we == WE_LOAD) ? mem_rdata : '0;
            end else if (tc) begin
               state_n = IDLE;
               valid_n = 1'b1;
               err_n   = 1'b1;
               rdata_n = DATA_W'(DMEM_ERR_DATA);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed scenarios plus randomized
// transactions against a transaction-level latency/data model.
module tb_dmem_bus_bridge;
   import core_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int BE_W    = DATA_W / 8;
   localparam int TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              core_req = 1'b0;
   logic              core_we_re = 1'b0;
   logic [BE_W-1:0]   core_mask = '0;
   logic [ADDR_W-1:0] core_addr = '0;
   logic [DATA_W-1:0] core_wdata = '0;
   logic              core_valid;
   logic [DATA_W-1:0] core_rdata;
   logic              core_err;
   logic              busy;
   logic              mem_req;
   logic              mem_we;
   logic [BE_W-1:0]   mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;
   logic [DATA_W:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   dmem_bus_bridge #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .core_req   (core_req),
      .core_we_re (core_we_re),
      .core_mask  (core_mask),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_valid (core_valid),
      .core_rdata (core_rdata),
      .core_err   (core_err),
      .busy       (busy),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (rst && core_valid) begin
         if (exp_q.size() == 0) check("unexpected_valid", core_valid, 1'b0);
         else check("completion", {core_err, core_rdata}, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   // Entered and left at a negedge. Core and slave inputs set here are seen
   // at the following posedge. A transaction needing n busy cycles finishes
   // normally when n <= TIMEOUT, otherwise after exactly TIMEOUT busy cycles.
   task automatic do_txn(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [BE_W-1:0] mask, input logic [DATA_W-1:0] wdata,
                         input int gnt_dly, input int rv_dly, input logic [DATA_W-1:0] rdata);
      int n_busy;
      int lat;
      int req_cycles;
      core_req   = 1'b1;
      core_we_re = we;
      core_mask  = mask;
      core_addr  = addr;
      core_wdata = wdata;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      n_busy = gnt_dly + rv_dly + 2;
      if (mask == '0) begin
         lat = 1;
         exp_q.push_back('0);
      end else if (n_busy <= TIMEOUT) begin
         lat = n_busy + 1;
         exp_q.push_back({1'b0, (we == WE_STORE) ? DATA_W'(0) : rdata});
      end else begin
         lat = TIMEOUT + 1;
         exp_q.push_back({1'b1, DATA_W'(0)});
      end
      req_cycles = (gnt_dly + 1 < TIMEOUT) ? gnt_dly + 1 : TIMEOUT;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == lat) begin
            check("done_flags", {core_valid, busy, mem_req}, 3'b100);
         end else begin
            check("busy_flags", {core_valid, busy}, 2'b01);
            if (k <= req_cycles)
               check("req_bus", {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
                     {1'b1, we, mask, addr, wdata});
            else
               check("resp_req_low", mem_req, 1'b0);
         end
         mem_rdata = $urandom;
         if (k < lat) begin
            core_req   = 1'($urandom_range(0, 1));
            core_we_re = 1'($urandom_range(0, 1));
            core_mask  = BE_W'($urandom);
            core_addr  = $urandom;
            core_wdata = $urandom;
            mem_gnt    = (k == gnt_dly + 1);
            if (k == gnt_dly + 2 + rv_dly) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rdata;
            end else if (k <= req_cycles) begin
               mem_rvalid = 1'($urandom_range(0, 1));
            end else begin
               mem_rvalid = 1'b0;
            end
         end else begin
            core_req   = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'($urandom_range(0, 1));
         end
      end
   endtask

   // Idle cycles with stray responses from the slave: none may complete.
   task automatic idle(input int n);
      core_req = 1'b0;
      mem_gnt  = 1'b0;
      for (int i = 0; i < n; i++) begin
         mem_rvalid = 1'($urandom_range(0, 1));
         mem_rdata  = $urandom;
         @(negedge clk);
         check("idle_no_valid", {core_valid, busy, mem_req}, 3'b000);
      end
      mem_rvalid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [BE_W-1:0] rmask;

   initial begin
      rst = 1'b0;
      core_req  = 1'b1;
      core_mask = '1;
      core_addr = 32'h55;
      repeat (3) @(negedge clk);
      check("reset_outputs", {core_valid, core_rdata, core_err, busy, mem_req, mem_we,
                              mem_be, mem_addr, mem_wdata}, '0);
      rst = 1'b1;
      idle(2);

      // load, zero-wait slave
      do_txn(WE_LOAD, 32'h100, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF);
      idle(2);
      // store with grant and response stalls
      do_txn(WE_STORE, 32'h204, 4'h1, 32'h000000AB, 3, 2, 32'h12345678);
      idle(2);
      // slave never grants, then stray responses in IDLE
      do_txn(WE_LOAD, 32'h400, 4'hF, 32'h0, 1000, 0, 32'h0);
      idle(6);
      // grant but response never arrives
      do_txn(WE_LOAD, 32'h404, 4'h3, 32'h0, 1, 1000, 32'h0);
      idle(2);
      // response lands exactly on the last permitted cycle, then one too late
      do_txn(WE_LOAD, 32'h408, 4'hF, 32'h0, 2, TIMEOUT - 4, 32'hCAFEF00D);
      do_txn(WE_LOAD, 32'h40C, 4'hF, 32'h0, 2, TIMEOUT - 3, 32'hBADC0DE0);
      idle(2);
      // back-to-back loads with core_req held high
      do_txn(WE_LOAD, 32'h0, 4'hF, 32'h0, 0, 0, 32'h11111111);
      do_txn(WE_LOAD, 32'h4, 4'hF, 32'h0, 0, 0, 32'h22222222);
      idle(2);
      // zero mask: immediate completion, slave untouched
      do_txn(WE_LOAD, 32'h500, 4'h0, 32'h0, 0, 0, 32'h0);
      do_txn(WE_STORE, 32'h504, 4'h0, 32'hFF, 0, 0, 32'h0);
      idle(2);

      // reset while waiting for the response
      core_req   = 1'b1;
      core_we_re = WE_LOAD;
      core_mask  = 4'hF;
      core_addr  = 32'h300;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      @(negedge clk);
      check("rst_mid_req", {busy, mem_req, mem_addr}, {2'b11, 32'h300});
      core_req = 1'b0;
      mem_gnt  = 1'b1;
      @(negedge clk);
      check("rst_mid_resp", {core_valid, busy, mem_req}, 3'b010);
      mem_gnt = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs", {core_valid, core_rdata, core_err, busy, mem_req, mem_we,
                                mem_be, mem_addr, mem_wdata}, '0);
      rst        = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA5A5A5A5;
      idle(4);

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         rmask = ($urandom_range(0, 9) == 0) ? '0 : BE_W'($urandom_range(1, 15));
         do_txn(1'($urandom_range(0, 1)), $urandom, rmask, $urandom,
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(3);

      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
